// File: rtl/effective_address_stage.sv
// Effective-address stage of the pipelined 6502 core.
// Direct modes resolve in one cycle; indirect modes fetch a 16-bit pointer
// over the shared data-memory read port (two bubbles, three-cycle latency).
module effective_address_stage #(
  parameter int CNTRL_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               gbl_stl_i,
  input  logic               wait_to_fill_pipe_i,
  input  logic               mem_stl_i,
  input  logic [3:0]         mode_i,
  input  logic [15:0]        opr_i,
  input  logic [7:0]         x_i,
  input  logic [7:0]         y_i,
  input  logic [15:0]        pc_i,
  input  logic [15:0]        dat_i,
  input  logic [CNTRL_W-1:0] control_signal_i,
  input  logic [7:0]         mem_rd_dat_i,
  output logic               mem_rd_en_o,
  output logic [15:0]        mem_rd_adr_o,
  output logic               stall_o,
  output logic [15:0]        eff_adr_o,
  output logic [15:0]        dat_o,
  output logic               page_crs_o,
  output logic [CNTRL_W-1:0] control_signal_o
);

  localparam logic [3:0] M_ZP   = 4'd2,  M_ZPX  = 4'd3,  M_ZPY = 4'd4;
  localparam logic [3:0] M_ABS  = 4'd5,  M_ABSX = 4'd6,  M_ABSY = 4'd7;
  localparam logic [3:0] M_IND  = 4'd8,  M_INDX = 4'd9,  M_INDY = 4'd10;
  localparam logic [3:0] M_REL  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_RD_LO, S_RD_HI} state_t;

  state_t               r_state, w_next_state;
  logic [15:0]          r_ptr;
  logic [7:0]           r_lo;
  logic                 r_indy;
  logic [15:0]          r_dat;
  logic [CNTRL_W-1:0]   r_ctrl;

  logic                 w_hold;
  logic                 w_is_ind;
  logic [15:0]          w_dir_adr;
  logic                 w_dir_pcrs;
  logic [15:0]          w_ptr;
  logic [15:0]          w_abs_x, w_abs_y;
  logic [7:0]           w_zp_x, w_zp_y;
  logic [15:0]          w_ind_base, w_ind_adr;
  logic                 w_ind_pcrs;
  logic                 w_stall, w_rd_en;
  logic [15:0]          w_rd_adr;

  assign w_hold   = gbl_stl_i | mem_stl_i | wait_to_fill_pipe_i;
  assign w_is_ind = (mode_i == M_IND) || (mode_i == M_INDX) || (mode_i == M_INDY);
  assign w_abs_x  = opr_i + {8'h00, x_i};
  assign w_abs_y  = opr_i + {8'h00, y_i};
  assign w_zp_x   = opr_i[7:0] + x_i;
  assign w_zp_y   = opr_i[7:0] + y_i;

  // Direct-mode address, page-cross flag and indirect pointer from the current inputs
  always_comb begin
    w_dir_adr  = 16'h0000;
    w_dir_pcrs = 1'b0;
    w_ptr      = {8'h00, opr_i[7:0]};
    case (mode_i)
      M_ZP:   w_dir_adr = {8'h00, opr_i[7:0]};
      M_ZPX:  w_dir_adr = {8'h00, w_zp_x};
      M_ZPY:  w_dir_adr = {8'h00, w_zp_y};
      M_ABS:  w_dir_adr = opr_i;
      M_ABSX: begin
        w_dir_adr  = w_abs_x;
        w_dir_pcrs = (w_abs_x[15:8] != opr_i[15:8]);
      end
      M_ABSY: begin
        w_dir_adr  = w_abs_y;
        w_dir_pcrs = (w_abs_y[15:8] != opr_i[15:8]);
      end
      M_REL:  w_dir_adr = pc_i + {{8{opr_i[7]}}, opr_i[7:0]};
      M_IND:  w_ptr     = opr_i;
      M_INDX: w_ptr     = {8'h00, w_zp_x};
      default: ;
    endcase
  end

  // Pointer high byte arrives in RD_HI; INDY adds Y to it in the same cycle
  assign w_ind_base = {mem_rd_dat_i, r_lo};
  assign w_ind_adr  = r_indy ? (w_ind_base + {8'h00, y_i}) : w_ind_base;
  assign w_ind_pcrs = r_indy && (w_ind_adr[15:8] != mem_rd_dat_i);

  // Next-state and read-port control; the high-byte read wraps within the pointer page
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_adr     = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_is_ind) begin
          w_stall      = 1'b1;
          w_next_state = S_RD_LO;
        end
      end
      S_RD_LO: begin
        w_rd_en      = 1'b1;
        w_rd_adr     = r_ptr;
        w_stall      = 1'b1;
        w_next_state = S_RD_HI;
      end
      S_RD_HI: begin
        w_rd_en      = 1'b1;
        w_rd_adr     = {r_ptr[15:8], r_ptr[7:0] + 8'd1};
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Reset forces the handshake outputs low even though the state is already IDLE
  assign stall_o      = w_stall & rst_i;
  assign mem_rd_en_o  = w_rd_en & rst_i;
  assign mem_rd_adr_o = rst_i ? w_rd_adr : 16'h0000;

  // State register, frozen by any stall source
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       r_state <= S_IDLE;
    else if (!w_hold) r_state <= w_next_state;
  end

  // Pointer capture, low-byte capture and output pipeline register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr            <= 16'h0000;
      r_lo             <= 8'h00;
      r_indy           <= 1'b0;
      r_dat            <= 16'h0000;
      r_ctrl           <= '0;
      eff_adr_o        <= 16'h0000;
      dat_o            <= 16'h0000;
      page_crs_o       <= 1'b0;
      control_signal_o <= '0;
    end else if (!w_hold) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_ind) begin
            r_ptr            <= w_ptr;
            r_indy           <= (mode_i == M_INDY);
            r_dat            <= dat_i;
            r_ctrl           <= control_signal_i;
            eff_adr_o        <= 16'h0000;
            dat_o            <= 16'h0000;
            page_crs_o       <= 1'b0;
            control_signal_o <= '0;
          end else begin
            eff_adr_o        <= w_dir_adr;
            dat_o            <= dat_i;
            page_crs_o       <= w_dir_pcrs;
            control_signal_o <= control_signal_i;
          end
        end
        S_RD_LO: r_lo <= mem_rd_dat_i;
        S_RD_HI: begin
          eff_adr_o        <= w_ind_adr;
          dat_o            <= r_dat;
          page_crs_o       <= w_ind_pcrs;
          control_signal_o <= r_ctrl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_effective_address_stage.sv
// Directed bench for effective_address_stage with a combinational memory model.
module tb_effective_address_stage;
  localparam int CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          gbl_stl_i, wait_to_fill_pipe_i, mem_stl_i;
  logic [3:0]    mode_i;
  logic [15:0]   opr_i, pc_i, dat_i;
  logic [7:0]    x_i, y_i;
  logic [CW-1:0] control_signal_i;
  logic [7:0]    mem_rd_dat_i;
  logic          mem_rd_en_o, stall_o, page_crs_o;
  logic [15:0]   mem_rd_adr_o, eff_adr_o, dat_o;
  logic [CW-1:0] control_signal_o;

  logic [7:0] mem [0:65535];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;
  assign mem_rd_dat_i = mem[mem_rd_adr_o];

  effective_address_stage #(.CNTRL_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .gbl_stl_i(gbl_stl_i),
    .wait_to_fill_pipe_i(wait_to_fill_pipe_i), .mem_stl_i(mem_stl_i),
    .mode_i(mode_i), .opr_i(opr_i), .x_i(x_i), .y_i(y_i), .pc_i(pc_i),
    .dat_i(dat_i), .control_signal_i(control_signal_i),
    .mem_rd_dat_i(mem_rd_dat_i), .mem_rd_en_o(mem_rd_en_o),
    .mem_rd_adr_o(mem_rd_adr_o), .stall_o(stall_o), .eff_adr_o(eff_adr_o),
    .dat_o(dat_o), .page_crs_o(page_crs_o), .control_signal_o(control_signal_o)
  );

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [15:0] o, input logic [CW-1:0] c, input logic [15:0] d);
    mode_i = m; opr_i = o; control_signal_i = c; dat_i = d;
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; mode_i = 4'd8; #3;
    n_total++; if ({eff_adr_o, dat_o, page_crs_o, control_signal_o} !== '0)
      $display("FAIL reset_outputs eff=%h dat=%h pc=%b ctl=%h want all 0", eff_adr_o, dat_o, page_crs_o, control_signal_o); else n_pass++;
    n_total++; if ({stall_o, mem_rd_en_o} !== 2'b00)
      $display("FAIL reset_stall stall=%b en=%b want 0 0", stall_o, mem_rd_en_o); else n_pass++;
    drive(4'd0, 16'h0, '0, 16'h0);
    tick; rst_i = 1'b1; #1;
  endtask

  task automatic test_zpx;
    x_i = 8'h20; drive(4'd3, 16'h00F0, 32'h0000_0003, 16'h00AA);
    n_total++; if (stall_o !== 1'b0) $display("FAIL zpx_stall got %b want 0", stall_o); else n_pass++;
    tick;
    n_total++; if (eff_adr_o !== 16'h0010 || page_crs_o !== 1'b0)
      $display("FAIL zpx_eff got %h/%b want 0010/0", eff_adr_o, page_crs_o); else n_pass++;
    n_total++; if (control_signal_o !== 32'h3 || dat_o !== 16'h00AA)
      $display("FAIL zpx_pass ctl=%h dat=%h want 3/00aa", control_signal_o, dat_o); else n_pass++;
  endtask

  task automatic test_abs_idx;
    y_i = 8'h20; drive(4'd7, 16'h12F0, 32'h7, 16'h0);
    tick;
    n_total++; if (eff_adr_o !== 16'h1310 || page_crs_o !== 1'b1)
      $display("FAIL absy got %h/%b want 1310/1", eff_adr_o, page_crs_o); else n_pass++;
    x_i = 8'h05; drive(4'd6, 16'h1200, 32'h6, 16'h0);
    tick;
    n_total++; if (eff_adr_o !== 16'h1205 || page_crs_o !== 1'b0)
      $display("FAIL absx got %h/%b want 1205/0", eff_adr_o, page_crs_o); else n_pass++;
    drive(4'd13, 16'h1234, 32'h9, 16'h0);
    tick;
    n_total++; if (eff_adr_o !== 16'h0000 || control_signal_o !== 32'h9)
      $display("FAIL mode13_imp got %h ctl=%h want 0000/9", eff_adr_o, control_signal_o); else n_pass++;
  endtask

  task automatic test_ind;
    mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'hEE;
    drive(4'd8, 16'h30FF, 32'hCAFE_0008, 16'h5555);
    n_total++; if (stall_o !== 1'b1 || mem_rd_en_o !== 1'b0)
      $display("FAIL ind_idle stall=%b en=%b want 1/0", stall_o, mem_rd_en_o); else n_pass++;
    tick;
    n_total++; if (control_signal_o !== '0 || stall_o !== 1'b1 || mem_rd_en_o !== 1'b1 || mem_rd_adr_o !== 16'h30FF)
      $display("FAIL ind_rdlo ctl=%h stall=%b en=%b adr=%h want 0/1/1/30ff", control_signal_o, stall_o, mem_rd_en_o, mem_rd_adr_o); else n_pass++;
    tick;
    n_total++; if (control_signal_o !== '0 || stall_o !== 1'b0 || mem_rd_en_o !== 1'b1 || mem_rd_adr_o !== 16'h3000)
      $display("FAIL ind_rdhi ctl=%h stall=%b en=%b adr=%h want 0/0/1/3000", control_signal_o, stall_o, mem_rd_en_o, mem_rd_adr_o); else n_pass++;
    tick;
    drive(4'd0, 16'h0, '0, 16'h0);
    n_total++; if (eff_adr_o !== 16'h5080 || control_signal_o !== 32'hCAFE_0008 || dat_o !== 16'h5555)
      $display("FAIL ind_result eff=%h ctl=%h dat=%h want 5080/cafe0008/5555", eff_adr_o, control_signal_o, dat_o); else n_pass++;
    n_total++; if (mem_rd_en_o !== 1'b0 || mem_rd_adr_o !== 16'h0000)
      $display("FAIL ind_back_idle en=%b adr=%h want 0/0000", mem_rd_en_o, mem_rd_adr_o); else n_pass++;
  endtask

  task automatic test_indy_indx;
    mem[16'h00FF] = 8'hF0; mem[16'h0000] = 8'h12; mem[16'h0100] = 8'hEE;
    y_i = 8'h20; drive(4'd10, 16'h00FF, 32'hA, 16'h0);
    tick; tick;
    n_total++; if (mem_rd_adr_o !== 16'h0000) $display("FAIL indy_hi_adr got %h want 0000", mem_rd_adr_o); else n_pass++;
    tick; drive(4'd0, 16'h0, '0, 16'h0);
    n_total++; if (eff_adr_o !== 16'h1310 || page_crs_o !== 1'b1 || control_signal_o !== 32'hA)
      $display("FAIL indy got %h/%b ctl=%h want 1310/1/a", eff_adr_o, page_crs_o, control_signal_o); else n_pass++;
    mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
    x_i = 8'h03; drive(4'd9, 16'h00FE, 32'hB, 16'h0);
    tick;
    n_total++; if (mem_rd_adr_o !== 16'h0001) $display("FAIL indx_lo_adr got %h want 0001", mem_rd_adr_o); else n_pass++;
    tick; tick; drive(4'd0, 16'h0, '0, 16'h0);
    n_total++; if (eff_adr_o !== 16'h1234 || page_crs_o !== 1'b0)
      $display("FAIL indx got %h/%b want 1234/0", eff_adr_o, page_crs_o); else n_pass++;
  endtask

  task automatic test_rel_and_hold;
    pc_i = 16'h0200; drive(4'd11, 16'h0080, 32'hC, 16'h0);
    tick;
    n_total++; if (eff_adr_o !== 16'h0180 || page_crs_o !== 1'b0)
      $display("FAIL rel got %h/%b want 0180/0", eff_adr_o, page_crs_o); else n_pass++;
    mem[16'h4010] = 8'h22; mem[16'h4011] = 8'h66;
    drive(4'd8, 16'h4010, 32'hD, 16'h0);
    tick; tick;
    mem_stl_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_total++; if (control_signal_o !== '0 || mem_rd_en_o !== 1'b1 || mem_rd_adr_o !== 16'h4011)
        $display("FAIL hold_rdhi_%0d ctl=%h en=%b adr=%h want 0/1/4011", i, control_signal_o, mem_rd_en_o, mem_rd_adr_o); else n_pass++;
    end
    mem_stl_i = 1'b0;
    tick; drive(4'd0, 16'h0, '0, 16'h0);
    n_total++; if (eff_adr_o !== 16'h6622 || control_signal_o !== 32'hD)
      $display("FAIL hold_result eff=%h ctl=%h want 6622/d", eff_adr_o, control_signal_o); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch;
    mem[16'h5000] = 8'h77;
    drive(4'd8, 16'h5000, 32'hE, 16'h1111);
    tick;
    rst_i = 1'b0; #1;
    n_total++; if ({stall_o, mem_rd_en_o, eff_adr_o, control_signal_o, page_crs_o} !== '0)
      $display("FAIL rst_mid stall=%b en=%b eff=%h ctl=%h want all 0", stall_o, mem_rd_en_o, eff_adr_o, control_signal_o); else n_pass++;
    drive(4'd0, 16'h0, '0, 16'h0);
    tick; rst_i = 1'b1; #1;
    n_total++; if (stall_o !== 1'b0 || mem_rd_en_o !== 1'b0)
      $display("FAIL rst_idle stall=%b en=%b want 0/0", stall_o, mem_rd_en_o); else n_pass++;
    drive(4'd5, 16'hABCD, 32'hF, 16'h0);
    tick;
    n_total++; if (eff_adr_o !== 16'hABCD || control_signal_o !== 32'hF)
      $display("FAIL rst_abs eff=%h ctl=%h want abcd/f", eff_adr_o, control_signal_o); else n_pass++;
  endtask

  initial begin
    gbl_stl_i = 1'b0; wait_to_fill_pipe_i = 1'b0; mem_stl_i = 1'b0;
    x_i = 8'h0; y_i = 8'h0; pc_i = 16'h0;
    mode_i = 4'd0; opr_i = 16'h0; dat_i = 16'h0; control_signal_i = '0;
    test_reset;
    test_zpx;
    test_abs_idx;
    test_ind;
    test_indy_indx;
    test_rel_and_hold;
    test_reset_mid_fetch;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/effective_address_stage.md
Name: effective_address_stage

Overview:
- Pipeline stage directly upstream of the read-data stage in the pipelined 6502 core.
- Takes each decoded instruction's addressing mode, operand, index registers and PC, and computes the 16-bit effective address.
- Direct modes complete in one cycle. Indirect modes fetch pointer bytes over the shared data-memory read port.
- Registers effective address, operand and control word for the read-data stage.

Parameters:
- CNTRL_W, 32, width of the control word passed downstream; all-zero word is a NOP/bubble

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- gbl_stl_i  in  1  global stall; all state and outputs hold
- wait_to_fill_pipe_i  in  1  pipe-fill wait; all state and outputs hold
- mem_stl_i  in  1  memory stall; all state and outputs hold
- mode_i  in  4  addressing mode (encoding below)
- opr_i  in  16  instruction operand (zp/offset in [7:0], abs in [15:0])
- x_i  in  8  X register, forwarded
- y_i  in  8  Y register, forwarded
- pc_i  in  16  address of next sequential instruction
- dat_i  in  16  data/immediate carried with the instruction
- control_signal_i  in  CNTRL_W  decoded control word
- mem_rd_dat_i  in  8  memory read data, combinational, same cycle as address
- mem_rd_en_o  out  1  pointer read request
- mem_rd_adr_o  out  16  pointer read address
- stall_o  out  1  freeze upstream stages
- eff_adr_o  out  16  registered effective address
- dat_o  out  16  registered dat_i
- page_crs_o  out  1  registered page-cross flag
- control_signal_o  out  CNTRL_W  registered control word

Behaviour:
- Mode encoding: 0 IMP, 1 IMM, 2 ZP, 3 ZPX, 4 ZPY, 5 ABS, 6 ABSX, 7 ABSY, 8 IND, 9 INDX, 10 INDY, 11 REL. Codes 12-15 are treated as IMP.
- Address rules, all sums mod 2^16 unless stated:
  - IMP/IMM: 0.
  - ZP: {8'h0, opr[7:0]}.
  - ZPX/ZPY: {8'h0, (opr[7:0]+idx) mod 256}.
  - ABS: opr.
  - ABSX/ABSY: opr + idx.
  - REL: pc_i + sign-extended opr[7:0].
- page_crs_o = 1 only for ABSX, ABSY and INDY when the base high byte differs from the result high byte; otherwise 0.
- Reset (rst_i low, asynchronous): state = IDLE; eff_adr_o, dat_o, control_signal_o and page_crs_o all 0. Pointer/low-byte registers cleared. stall_o and mem_rd_en_o are 0 while reset is asserted.
- Hold: any of gbl_stl_i, mem_stl_i or wait_to_fill_pipe_i high freezes FSM, pointer registers and outputs. Combinational stall_o and mem_rd_* keep their state-derived values.
- FSM states: IDLE, RD_LO, RD_HI.
- IDLE, direct mode:
  - stall_o = 0.
  - Next edge registers eff_adr_o, dat_o, control_signal_o and page_crs_o (latency 1).
- IDLE, mode IND/INDX/INDY:
  - stall_o = 1 combinationally.
  - Next edge latches pointer P, dat_i and control word, then moves to RD_LO.
  - P values: IND: opr. INDX: {8'h0, (opr[7:0]+x_i) mod 256}. INDY: {8'h0, opr[7:0]}.
  - Outputs register a bubble: control_signal_o = 0, page_crs_o = 0.
- RD_LO:
  - mem_rd_en_o = 1, mem_rd_adr_o = P, stall_o = 1.
  - Edge latches lo = mem_rd_dat_i and moves to RD_HI.
  - control_signal_o remains 0.
- RD_HI:
  - mem_rd_en_o = 1, stall_o = 0.
  - mem_rd_adr_o = {P[15:8], (P[7:0]+1) mod 256]}. This reproduces the NMOS page-wrap for IND and the zero-page wrap for INDX/INDY.
  - Edge registers eff_adr_o = {mem_rd_dat_i, lo}, or that value + y_i for INDY.
  - Same edge registers latched dat and control word to the outputs, sets page_crs_o, and returns to IDLE.
  - Upstream advances on this same edge.
- Indirect latency: 3 cycles; exactly 2 bubbles emitted.
- Index inputs are sampled at the moment of use: x_i in IDLE, y_i in RD_HI. They must be stable under forwarding.
- mem_rd_en_o = 0 and mem_rd_adr_o = 0 in IDLE.
- Reset asserted in RD_LO/RD_HI aborts the fetch with no output. The instruction is discarded.

Test Plan:
- ZPX, opr=0x00F0, x_i=0x20 -> one cycle later eff_adr_o=0x0010, page_crs_o=0; stall_o never high.
- ABSY, opr=0x12F0, y_i=0x20 -> eff_adr_o=0x1310, page_crs_o=1. ABSX, opr=0x1200, x_i=0x05 -> 0x1205, page_crs_o=0.
- IND, opr=0x30FF, mem[30FF]=0x80, mem[3000]=0x50 -> reads at 0x30FF then 0x3000; stall_o high 2 cycles; control_signal_o=0 for 2 cycles, then eff_adr_o=0x5080 with original control word.
- INDY, opr=0x00FF, mem[00FF]=0xF0, mem[0000]=0x12, y_i=0x20 -> eff_adr_o=0x1310, page_crs_o=1. INDX, opr=0x00FE, x_i=0x03, mem[0001]=0x34, mem[0002]=0x12 -> eff_adr_o=0x1234.
- REL, pc_i=0x0200, opr[7:0]=0x80 -> eff_adr_o=0x0180. mem_stl_i high 2 cycles during RD_HI -> state, address and outputs frozen; result unchanged afterwards.
- rst_i pulsed low mid-RD_LO -> all outputs 0 immediately; stall_o=0; IDLE after release; next ABS opr=0xABCD -> eff_adr_o=0xABCD.
